// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - sdc_controller register-bus sequencer: card init, CMD17 reads, status polling
// Optional poll timeout enabled by defining SD_SEQ_TIMEOUT_EN.
module sd_cmd_sequencer #(
    parameter int unsigned INIT_DELAY = 256,
    parameter logic [15:0] RCA        = 16'h0020,
    parameter int unsigned POLL_GAP   = 16
`ifdef SD_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT  = 65535
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [15:0] rd_blk,
    output logic        ready,
    output logic        init_done,
    output logic        rd_done,
    output logic        rd_err,
    output logic [6:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    input  logic [7:0]  reg_rdata
);

    typedef enum logic [2:0] {
        INIT0, WR_SETUP, WR_STROBE, INIT_WAIT,
        POLL_ADDR, POLL_SAMPLE, POLL_WAIT, IDLE
    } state_t;

    // Write script: 0-1 CMD0, 2-5 CMD7 select, 6-11 CMD17 read.
    localparam logic [3:0] IDX_CMD0_LAST  = 4'd1;
    localparam logic [3:0] IDX_CMD7_FIRST = 4'd2;
    localparam logic [3:0] IDX_CMD7_LAST  = 4'd5;
    localparam logic [3:0] IDX_RD_FIRST   = 4'd6;
    localparam logic [3:0] IDX_RD_LAST    = 4'd11;

    state_t      state, state_next;
    logic [3:0]  idx, idx_next;
    logic [15:0] blk;
    logic [15:0] wait_cnt, wait_next;
    logic        accept, cmd_end, cmd_err;
    logic        unused_rdata;

`ifdef SD_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt, poll_next;
`endif

    assign unused_rdata = &{1'b0, reg_rdata[7:2]};
    assign ready        = (state == IDLE);

    function automatic logic [14:0] script_entry(input logic [3:0] i, input logic [15:0] b);
        case (i)
            4'd0:    script_entry = {7'd5,  8'd0};
            4'd1:    script_entry = {7'd0,  8'd0};
            4'd2:    script_entry = {7'd5,  8'd7};
            4'd3:    script_entry = {7'd4,  8'd0};
            4'd4:    script_entry = {7'd3,  RCA[15:8]};
            4'd5:    script_entry = {7'd0,  8'd0};
            4'd6:    script_entry = {7'h48, 8'd0};
            4'd7:    script_entry = {7'd5,  8'd17};
            4'd8:    script_entry = {7'd4,  8'h3D};
            4'd9:    script_entry = {7'd3,  b[15:8]};
            4'd10:   script_entry = {7'd2,  b[7:0]};
            default: script_entry = {7'd0,  8'd0};
        endcase
    endfunction

    always_comb begin
        state_next = state;
        idx_next   = idx;
        wait_next  = wait_cnt;
        accept     = 1'b0;
        cmd_end    = 1'b0;
        cmd_err    = 1'b0;
        reg_addr   = 7'd0;
        reg_wdata  = 8'd0;
        reg_we     = 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
        poll_next  = poll_cnt;
`endif
        case (state)
            INIT0: begin
                idx_next   = 4'd0;
                state_next = WR_SETUP;
            end
            WR_SETUP: begin
                {reg_addr, reg_wdata} = script_entry(idx, blk);
                state_next = WR_STROBE;
            end
            WR_STROBE: begin
                {reg_addr, reg_wdata} = script_entry(idx, blk);
                reg_we = 1'b1;
                if (idx == IDX_CMD0_LAST) begin
                    wait_next = 16'd0;
                    if (INIT_DELAY == 0) begin
                        idx_next   = IDX_CMD7_FIRST;
                        state_next = WR_SETUP;
                    end else begin
                        state_next = INIT_WAIT;
                    end
                end else if (idx == IDX_CMD7_LAST || idx == IDX_RD_LAST) begin
                    state_next = POLL_ADDR;
`ifdef SD_SEQ_TIMEOUT_EN
                    poll_next  = 16'd0;
`endif
                end else begin
                    idx_next   = idx + 4'd1;
                    state_next = WR_SETUP;
                end
            end
            INIT_WAIT: begin
                if (wait_cnt == 16'(INIT_DELAY - 1)) begin
                    idx_next   = IDX_CMD7_FIRST;
                    state_next = WR_SETUP;
                end else begin
                    wait_next = wait_cnt + 16'd1;
                end
            end
            POLL_ADDR: begin
                reg_addr   = 7'h01;
                state_next = POLL_SAMPLE;
            end
            POLL_SAMPLE: begin
                reg_addr = 7'h01;
                if (!reg_rdata[0]) begin
                    cmd_end = 1'b1;
                    cmd_err = reg_rdata[1];
                end
`ifdef SD_SEQ_TIMEOUT_EN
                // Saturating poll count; a still-busy status at the limit is a failure.
                poll_next = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
                if (reg_rdata[0] && poll_next >= 16'(TIMEOUT)) begin
                    cmd_end = 1'b1;
                    cmd_err = 1'b1;
                end
`endif
                if (cmd_end) begin
                    state_next = (idx == IDX_CMD7_LAST && cmd_err) ? INIT0 : IDLE;
                end else if (POLL_GAP == 0) begin
                    state_next = POLL_ADDR;
                end else begin
                    wait_next  = 16'd0;
                    state_next = POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                if (wait_cnt == 16'(POLL_GAP - 1)) begin
                    state_next = POLL_ADDR;
                end else begin
                    wait_next = wait_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (rd_req) begin
                    accept     = 1'b1;
                    idx_next   = IDX_RD_FIRST;
                    state_next = WR_SETUP;
                end
            end
            default: state_next = INIT0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT0;
            idx       <= 4'd0;
            blk       <= 16'd0;
            wait_cnt  <= 16'd0;
            init_done <= 1'b0;
            rd_done   <= 1'b0;
            rd_err    <= 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
            poll_cnt  <= 16'd0;
`endif
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            wait_cnt <= wait_next;
            if (accept) begin
                blk <= rd_blk;
            end
            rd_done <= cmd_end && (idx == IDX_RD_LAST);
            rd_err  <= cmd_end && (idx == IDX_RD_LAST) && cmd_err;
            if (cmd_end && idx == IDX_CMD7_LAST && !cmd_err) begin
                init_done <= 1'b1;
            end
`ifdef SD_SEQ_TIMEOUT_EN
            poll_cnt <= poll_next;
`endif
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - self-checking bench for sd_cmd_sequencer with a behavioural controller model
module tb_sd_cmd_sequencer;

    localparam int INIT_DELAY = 256;
    localparam int POLL_GAP   = 16;
    localparam int RD_LAT     = 15;
    localparam int POLL_COST  = 2 + POLL_GAP;
    localparam int TMO        = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        rd_req = 1'b0;
    logic [15:0] rd_blk = 16'd0;
    logic        ready, init_done, rd_done, rd_err, reg_we;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_wdata, reg_rdata;

    sd_cmd_sequencer #(
        .INIT_DELAY(INIT_DELAY),
        .RCA(16'h0020),
        .POLL_GAP(POLL_GAP)
`ifdef SD_SEQ_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_blk(rd_blk),
        .ready(ready), .init_done(init_done), .rd_done(rd_done), .rd_err(rd_err),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller status model: busy for busy_n status samples after base, error on the final one.
    int   poll_count = 0;
    int   base       = 0;
    int   busy_n     = 0;
    bit   stuck      = 1'b0;
    bit   err_flag   = 1'b0;
    logic in_poll    = 1'b0;
    logic pend       = 1'b0;
    logic busy;
    assign busy      = stuck || ((poll_count - base) < busy_n);
    assign reg_rdata = {6'b0, err_flag & ~busy, busy};

    always @(negedge clk) begin
        if (pend) poll_count <= poll_count + 1;
        pend <= 1'b0;
        if (rst_n && reg_addr == 7'h01 && !reg_we) begin
            if (in_poll) begin
                pend    <= 1'b1;
                in_poll <= 1'b0;
            end else begin
                in_poll <= 1'b1;
            end
        end else begin
            in_poll <= 1'b0;
        end
    end

    typedef struct {
        int         c;
        logic [6:0] a;
        logic [7:0] d;
        logic       setup_ok;
    } wr_t;
    wr_t        wlog[$];
    logic [6:0] p_a  = 7'd0;
    logic [7:0] p_d  = 8'd0;
    logic       p_we = 1'b0;

    always @(negedge clk) begin
        if (rst_n && reg_we)
            wlog.push_back('{cyc, reg_addr, reg_wdata, (!p_we && p_a == reg_addr && p_d == reg_wdata)});
        p_a  <= reg_addr;
        p_d  <= reg_wdata;
        p_we <= reg_we;
    end

    int          total = 0;
    int          bad   = 0;
    int          rdp   = 0;
    logic [14:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_init_script();
        expq.push_back({7'd5, 8'd0});
        expq.push_back({7'd0, 8'd0});
        expq.push_back({7'd5, 8'd7});
        expq.push_back({7'd4, 8'd0});
        expq.push_back({7'd3, 8'h00});
        expq.push_back({7'd0, 8'd0});
    endtask

    task automatic add_cmd17(input logic [15:0] b);
        expq.push_back({7'h48, 8'h00});
        expq.push_back({7'd5, 8'd17});
        expq.push_back({7'd4, 8'h3D});
        expq.push_back({7'd3, b[15:8]});
        expq.push_back({7'd2, b[7:0]});
        expq.push_back({7'd0, 8'd0});
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, wlog.size() - rdp, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (rdp + i < wlog.size()) begin
                chk($sformatf("%s_wr%0d", tag, i), {wlog[rdp + i].a, wlog[rdp + i].d}, expq[i]);
                chk($sformatf("%s_setup%0d", tag, i), wlog[rdp + i].setup_ok, 1);
            end
        end
        rdp = wlog.size();
    endtask

    task automatic wait_init(input string tag);
        bit got = 1'b0;
        int t_init = 0;
        for (int k = 0; k < INIT_DELAY + 200; k++) begin
            @(negedge clk);
            if (init_done) begin
                got    = 1'b1;
                t_init = cyc;
                break;
            end
        end
        chk({tag, "_init_done"}, got, 1);
        chk({tag, "_ready"}, ready, 1);
        if (wlog.size() >= rdp + 6) begin
            chk({tag, "_gap"}, wlog[rdp + 2].c - wlog[rdp + 1].c, INIT_DELAY + 2);
            chk({tag, "_done_lat"}, t_init - wlog[rdp + 5].c, 3);
        end
        expq.delete();
        add_init_script();
        check_writes(tag);
    endtask

    task automatic do_read(input string tag, input logic [15:0] b, input int nbusy,
                           input bit eflag, input bit stk);
        bit   exp_done;
        int   exp_lat;
        logic exp_e;
        int   lim, t;
        bit   got = 1'b0;
        if (stk) begin
`ifdef SD_SEQ_TIMEOUT_EN
            exp_done = 1'b1;
            exp_lat  = RD_LAT + POLL_COST * (TMO - 1);
            exp_e    = 1'b1;
`else
            exp_done = 1'b0;
            exp_lat  = 0;
            exp_e    = 1'b0;
`endif
        end else begin
            exp_done = 1'b1;
            exp_lat  = RD_LAT + POLL_COST * nbusy;
            exp_e    = eflag;
        end
        lim = exp_done ? exp_lat + 40 : 10000;
        @(negedge clk);
        base     = poll_count;
        busy_n   = nbusy;
        err_flag = eflag;
        stuck    = stk;
        chk({tag, "_ready_before"}, ready, 1);
        rd_blk = b;
        rd_req = 1'b1;
        t      = cyc;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            rd_req = 1'b0;
            rd_blk = 16'($urandom);
            if (rd_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, got, exp_done);
        if (got && exp_done) begin
            chk({tag, "_lat"}, cyc - t, exp_lat);
            chk({tag, "_err"}, rd_err, exp_e);
            chk({tag, "_ready_at_done"}, ready, 1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, rd_done, 0);
        end
        expq.delete();
        add_cmd17(b);
        check_writes(tag);
    endtask

    task automatic spam_test();
        logic [15:0] b1, b2;
        int t, dones;
        bit got;
        b1 = 16'($urandom);
        b2 = 16'($urandom);
        @(negedge clk);
        base = poll_count; busy_n = 0; err_flag = 1'b0; stuck = 1'b0;
        rd_blk = b1;
        rd_req = 1'b1;
        t = cyc;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rd_done) begin got = 1'b1; break; end
            rd_blk = 16'($urandom);
        end
        chk("spam_first_done", got, 1);
        chk("spam_first_lat", cyc - t, RD_LAT);
        rd_blk = b2;
        t = cyc;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            rd_req = 1'b0;
            rd_blk = 16'($urandom);
            if (rd_done) begin got = 1'b1; break; end
        end
        chk("spam_second_done", got, 1);
        chk("spam_second_lat", cyc - t, RD_LAT);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rd_done) dones++;
        end
        chk("spam_no_extra_done", dones, 0);
        expq.delete();
        add_cmd17(b1);
        add_cmd17(b2);
        check_writes("spam");
    endtask

    initial begin
        bit found;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rd_done", rd_done, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        rdp   = wlog.size();
        rst_n = 1'b1;
        wait_init("init");

        do_read("blk1234", 16'h1234, 0, 1'b0, 1'b0);
        do_read("busy3_err", 16'($urandom), 3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            do_read($sformatf("rand%0d", i), 16'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0);
        spam_test();
        do_read("stuck", 16'($urandom), 0, 1'b0, 1'b1);

        stuck = 1'b0;
        repeat (60) @(negedge clk);
        rdp = wlog.size();
        base = poll_count; busy_n = 0; err_flag = 1'b0;
        chk("midrst_ready_before", ready, 1);
        rd_blk = 16'($urandom);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (reg_we && reg_addr == 7'd5) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("midrst_strobe_seen", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_reg_we", reg_we, 0);
        chk("midrst_reg_addr", reg_addr, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_init_done", init_done, 0);
        repeat (2) @(negedge clk);
        rdp   = wlog.size();
        rst_n = 1'b1;
        wait_init("replay");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
